// File: rtl/udp_pkg.sv
// Shared types and helpers for the UDP transmit payload path.
//   bank_state_t : per-bank ownership state of the ping-pong buffer
//   udp_len()    : UDP length from the payload byte count
//   ip_len()     : IPv4 total length from the payload byte count
package udp_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        TX
    } bank_state_t;

    localparam int unsigned UDP_HDR_BYTES = 8;
    localparam int unsigned IP_HDR_BYTES  = 20;

    function automatic logic [15:0] udp_len(input logic [15:0] bytes);
        return bytes + 16'(UDP_HDR_BYTES);
    endfunction

    function automatic logic [15:0] ip_len(input logic [15:0] bytes);
        return udp_len(bytes) + 16'(IP_HDR_BYTES);
    endfunction

endpackage

// File: rtl/udp_pp_ram.sv
// Simple dual-port synchronous RAM with a registered read port.
//   clk      : clock, both ports
//   reset    : synchronous active-high, clears only the read register
//   we_i     : write enable
//   waddr_i  : write word address
//   wdata_i  : write data
//   raddr_i  : read word address
//   rdata_o  : read data, one cycle after raddr_i
module udp_pp_ram #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [2**AW];
    logic [WIDTH-1:0] rdata_d, rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_d = mem[raddr_i];

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/udp_tx_payload_buf.sv
// Ping-pong payload buffer for the UDP transmitter.
// The source fills the write bank through a valid/ready port while the
// transmitter reads the other bank; committed frames are handed over with
// their UDP and IP lengths.
//   clk, reset               : clock, synchronous active-high reset
//   wr_valid/wr_data/wr_last : source word, last-word flag
//   wr_last_bytes            : valid bytes in the last word (0 means 4)
//   wr_ready                 : word accepted this cycle when valid
//   ram_rd_addr/ram_rd_data  : transmitter read port, 1-cycle latency
//   tx_req/tx_done           : frame ownership handshake with the transmitter
//   tx_data_length           : UDP length of the frame under transmission
//   tx_total_length          : IP total length of the frame under transmission
//   ovf                      : sticky, a frame was truncated at bank depth
//   frame_cnt                : frames handed to the transmitter
module udp_tx_payload_buf #(
    parameter int unsigned BANK_AW = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_valid,
    input  logic [31:0] wr_data,
    input  logic        wr_last,
    input  logic [2:0]  wr_last_bytes,
    output logic        wr_ready,
    input  logic [8:0]  ram_rd_addr,
    output logic [31:0] ram_rd_data,
    output logic        tx_req,
    input  logic        tx_done,
    output logic [15:0] tx_data_length,
    output logic [15:0] tx_total_length,
    output logic        ovf,
    output logic [15:0] frame_cnt
);

    import udp_pkg::*;

    localparam logic [15:0]        FULL_BYTES = 16'(4 * (2 ** BANK_AW));
    localparam logic [BANK_AW-1:0] WADDR_ONE  = BANK_AW'(1);

    bank_state_t        bank_st_q [2];
    bank_state_t        bank_st_d [2];
    logic [15:0]        bank_cnt_q [2];
    logic [15:0]        bank_cnt_d [2];
    logic               wbank_q, wbank_d;
    logic [BANK_AW-1:0] waddr_q, waddr_d;
    logic               tx_req_q, tx_req_d;
    logic [15:0]        data_len_q, data_len_d;
    logic [15:0]        total_len_q, total_len_d;
    logic               ovf_q, ovf_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;

    logic        rbank;
    logic        wr_fire;
    logic [15:0] last_bytes;
    logic        unused_rd_addr;

    assign rbank    = ~wbank_q;
    assign wr_ready = (bank_st_q[wbank_q] == EMPTY) || (bank_st_q[wbank_q] == FILLING);
    assign wr_fire  = wr_valid && wr_ready;
    assign last_bytes = (wr_last_bytes == 3'd0) ? 16'd4 : {13'd0, wr_last_bytes};
    assign unused_rd_addr = ^ram_rd_addr[8:BANK_AW];

    always_comb begin
        bank_st_d   = bank_st_q;
        bank_cnt_d  = bank_cnt_q;
        wbank_d     = wbank_q;
        waddr_d     = waddr_q;
        tx_req_d    = tx_req_q;
        data_len_d  = data_len_q;
        total_len_d = total_len_q;
        ovf_d       = ovf_q;
        frame_cnt_d = frame_cnt_q;

        // Write side: accept, and commit on wr_last or when the bank is full.
        if (wr_fire) begin
            waddr_d = waddr_q + WADDR_ONE;
            bank_st_d[wbank_q] = FILLING;
            if (wr_last || (waddr_q == '1)) begin
                bank_st_d[wbank_q] = FULL;
                waddr_d = '0;
                if (wr_last) begin
                    bank_cnt_d[wbank_q] = ({{(16 - BANK_AW){1'b0}}, waddr_q} << 2) + last_bytes;
                end else begin
                    bank_cnt_d[wbank_q] = FULL_BYTES;
                    ovf_d = 1'b1;
                end
            end
        end

        // Release; a tx_done for a bank not in TX is ignored.
        if (tx_done && (bank_st_q[rbank] == TX)) begin
            bank_st_d[rbank] = EMPTY;
            tx_req_d = 1'b0;
        end

        // Handover. Requires the read bank EMPTY, which only happens a cycle after
        // release, so tx_req always has a low cycle between frames.
        if ((bank_st_q[rbank] == EMPTY) && (bank_st_q[wbank_q] == FULL)) begin
            wbank_d = rbank;
            bank_st_d[wbank_q] = TX;
            data_len_d  = udp_len(bank_cnt_q[wbank_q]);
            total_len_d = ip_len(bank_cnt_q[wbank_q]);
            tx_req_d    = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_st_q[0]  <= EMPTY;
            bank_st_q[1]  <= EMPTY;
            bank_cnt_q[0] <= '0;
            bank_cnt_q[1] <= '0;
            wbank_q       <= 1'b0;
            waddr_q       <= '0;
            tx_req_q      <= 1'b0;
            data_len_q    <= '0;
            total_len_q   <= '0;
            ovf_q         <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            bank_st_q     <= bank_st_d;
            bank_cnt_q    <= bank_cnt_d;
            wbank_q       <= wbank_d;
            waddr_q       <= waddr_d;
            tx_req_q      <= tx_req_d;
            data_len_q    <= data_len_d;
            total_len_q   <= total_len_d;
            ovf_q         <= ovf_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign tx_req          = tx_req_q;
    assign tx_data_length  = data_len_q;
    assign tx_total_length = total_len_q;
    assign ovf             = ovf_q;
    assign frame_cnt       = frame_cnt_q;

    // Bank select is the address MSB so both banks share one RAM.
    udp_pp_ram #(
        .WIDTH (32),
        .AW    (BANK_AW + 1)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (wr_fire),
        .waddr_i ({wbank_q, waddr_q}),
        .wdata_i (wr_data),
        .raddr_i ({rbank, ram_rd_addr[BANK_AW-1:0]}),
        .rdata_o (ram_rd_data)
    );

endmodule

// File: tb/tb_udp_tx_payload_buf.sv
// Directed bench for udp_tx_payload_buf.
module tb_udp_tx_payload_buf;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_last = 1'b0;
    logic [2:0]  wr_last_bytes = '0;
    logic        wr_ready;
    logic [8:0]  ram_rd_addr = '0;
    logic [31:0] ram_rd_data;
    logic        tx_req;
    logic        tx_done = 1'b0;
    logic [15:0] tx_data_length;
    logic [15:0] tx_total_length;
    logic        ovf;
    logic [15:0] frame_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    udp_tx_payload_buf #(
        .BANK_AW (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .wr_valid        (wr_valid),
        .wr_data         (wr_data),
        .wr_last         (wr_last),
        .wr_last_bytes   (wr_last_bytes),
        .wr_ready        (wr_ready),
        .ram_rd_addr     (ram_rd_addr),
        .ram_rd_data     (ram_rd_data),
        .tx_req          (tx_req),
        .tx_done         (tx_done),
        .tx_data_length  (tx_data_length),
        .tx_total_length (tx_total_length),
        .ovf             (ovf),
        .frame_cnt       (frame_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one word and wait (bounded) until it is accepted.
    task automatic send(input logic [31:0] d, input bit last, input logic [2:0] lb);
        int n = 0;
        wr_valid = 1'b1;
        wr_data = d;
        wr_last = last;
        wr_last_bytes = lb;
        while (!wr_ready && n < 50) begin
            step();
            n++;
        end
        chk("send_ready", {31'd0, wr_ready}, 32'd1);
        step();
        wr_valid = 1'b0;
        wr_last = 1'b0;
    endtask

    task automatic rd(input logic [8:0] a, input logic [31:0] exp, input string tag);
        ram_rd_addr = a;
        step();
        chk(tag, ram_rd_data, exp);
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    initial begin
        // Reset values
        step();
        step();
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        chk("rst_tx_req", {31'd0, tx_req}, 32'd0);
        chk("rst_data_len", {16'd0, tx_data_length}, 32'd0);
        chk("rst_total_len", {16'd0, tx_total_length}, 32'd0);
        chk("rst_rd_data", ram_rd_data, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        reset = 1'b0;
        step();

        // Frame A: 3 words, 10 bytes -> 18/38
        send(32'h1122_3344, 1'b0, 3'd0);
        send(32'h5566_7788, 1'b0, 3'd0);
        send(32'h99AA_BBCC, 1'b1, 3'd2);
        chk("a_req_not_yet", {31'd0, tx_req}, 32'd0);
        step();
        chk("a_req", {31'd0, tx_req}, 32'd1);
        chk("a_data_len", {16'd0, tx_data_length}, 32'd18);
        chk("a_total_len", {16'd0, tx_total_length}, 32'd38);
        chk("a_frame_cnt", {16'd0, frame_cnt}, 32'd1);
        rd(9'd0, 32'h1122_3344, "a_rd0");
        rd(9'd1, 32'h5566_7788, "a_rd1");
        rd(9'd2, 32'h99AA_BBCC, "a_rd2");

        // Frame B written while A is in TX: 16 bytes -> 24/44
        send(32'hB000_0001, 1'b0, 3'd0);
        send(32'hB000_0002, 1'b0, 3'd0);
        send(32'hB000_0003, 1'b0, 3'd0);
        send(32'hB000_0004, 1'b1, 3'd4);
        chk("b_stall", {31'd0, wr_ready}, 32'd0);
        chk("a_hold_req", {31'd0, tx_req}, 32'd1);
        chk("a_hold_len", {16'd0, tx_data_length}, 32'd18);

        // Frame C offered while stalled
        wr_valid = 1'b1;
        wr_data = 32'hC000_0000;
        step();
        step();
        chk("c_stall", {31'd0, wr_ready}, 32'd0);
        chk("a_hold_total", {16'd0, tx_total_length}, 32'd38);
        pulse_done();
        chk("a_release_req", {31'd0, tx_req}, 32'd0);
        chk("a_release_stall", {31'd0, wr_ready}, 32'd0);
        step();
        chk("b_req", {31'd0, tx_req}, 32'd1);
        chk("b_data_len", {16'd0, tx_data_length}, 32'd24);
        chk("b_total_len", {16'd0, tx_total_length}, 32'd44);
        chk("b_frame_cnt", {16'd0, frame_cnt}, 32'd2);
        ram_rd_addr = 9'd0;
        send(32'hC000_0000, 1'b0, 3'd0);
        chk("b_rd0", ram_rd_data, 32'hB000_0001);
        send(32'hC000_0001, 1'b0, 3'd0);

        // Commit of C coincides with tx_done of B: 11 bytes -> 19/39
        wr_valid = 1'b1;
        wr_data = 32'hC000_0002;
        wr_last = 1'b1;
        wr_last_bytes = 3'd3;
        tx_done = 1'b1;
        step();
        wr_valid = 1'b0;
        wr_last = 1'b0;
        tx_done = 1'b0;
        chk("cb_gap_req", {31'd0, tx_req}, 32'd0);
        chk("cb_gap_ready", {31'd0, wr_ready}, 32'd0);
        step();
        chk("c_req", {31'd0, tx_req}, 32'd1);
        chk("c_data_len", {16'd0, tx_data_length}, 32'd19);
        chk("c_total_len", {16'd0, tx_total_length}, 32'd39);
        chk("c_frame_cnt", {16'd0, frame_cnt}, 32'd3);
        rd(9'd0, 32'hC000_0000, "c_rd0");
        rd(9'd1, 32'hC000_0001, "c_rd1");
        rd(9'd2, 32'hC000_0002, "c_rd2");
        pulse_done();
        chk("c_release_req", {31'd0, tx_req}, 32'd0);

        // Overflow: 256 words with no wr_last -> 1032/1052
        for (int i = 0; i < 256; i++) begin
            send(32'h1000_0000 + i, 1'b0, 3'd0);
        end
        chk("ovf_set", {31'd0, ovf}, 32'd1);
        step();
        chk("ovf_req", {31'd0, tx_req}, 32'd1);
        chk("ovf_data_len", {16'd0, tx_data_length}, 32'd1032);
        chk("ovf_total_len", {16'd0, tx_total_length}, 32'd1052);
        chk("ovf_frame_cnt", {16'd0, frame_cnt}, 32'd4);
        rd(9'd0, 32'h1000_0000, "ovf_rd0");
        rd(9'd255, 32'h1000_00FF, "ovf_rd255");
        pulse_done();
        chk("ovf_release_req", {31'd0, tx_req}, 32'd0);

        // Remaining 44 words form the next frame: 176 bytes -> 184/204
        for (int i = 256; i < 300; i++) begin
            send(32'h1000_0000 + i, i == 299, 3'd4);
        end
        step();
        chk("rest_req", {31'd0, tx_req}, 32'd1);
        chk("rest_data_len", {16'd0, tx_data_length}, 32'd184);
        chk("rest_total_len", {16'd0, tx_total_length}, 32'd204);
        chk("rest_frame_cnt", {16'd0, frame_cnt}, 32'd5);
        chk("ovf_sticky", {31'd0, ovf}, 32'd1);
        rd(9'd0, 32'h1000_0100, "rest_rd0");
        rd(9'd43, 32'h1000_012B, "rest_rd43");

        // Reset during TX with a partial frame in the write bank
        send(32'hEEEE_0000, 1'b0, 3'd0);
        send(32'hEEEE_0001, 1'b0, 3'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2_tx_req", {31'd0, tx_req}, 32'd0);
        chk("rst2_wr_ready", {31'd0, wr_ready}, 32'd1);
        chk("rst2_ovf", {31'd0, ovf}, 32'd0);
        chk("rst2_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("rst2_data_len", {16'd0, tx_data_length}, 32'd0);

        // One word, wr_last_bytes=0 means 4 bytes -> 12/32
        send(32'hDEAD_BEEF, 1'b1, 3'd0);
        step();
        chk("one_req", {31'd0, tx_req}, 32'd1);
        chk("one_data_len", {16'd0, tx_data_length}, 32'd12);
        chk("one_total_len", {16'd0, tx_total_length}, 32'd32);
        chk("one_frame_cnt", {16'd0, frame_cnt}, 32'd1);
        rd(9'h100, 32'hDEAD_BEEF, "one_rd_msb_ignored");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
